// File: rtl/button_ctrl.sv
// Input conditioning for four active-low push buttons: synchronize, debounce,
// pick one direction by fixed priority and emit auto-repeating move strobes.
module button_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 2000000,
  parameter int unsigned CNT_W           = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       up_but,
  input  logic       down_but,
  input  logic       left_but,
  input  logic       right_but,
  output logic [3:0] held,
  output logic       move_valid,
  output logic [1:0] move_dir
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT
  } state_t;

  logic [3:0] raw;
  logic [3:0] sync1_q, sync2_q;
  logic [3:0] acc_q, acc_d;
  logic [CNT_W-1:0] db_cnt_q [4];
  logic [CNT_W-1:0] db_cnt_d [4];

  logic       sel_valid;
  logic [1:0] sel_dir;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             valid_q, valid_d;
  logic [1:0]       dir_q, dir_d;

  assign raw = {right_but, left_but, down_but, up_but};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Accepted levels are kept in raw (active-low) polarity; held is the inverse.
  always_comb begin
    acc_d = acc_q;
    for (int unsigned i = 0; i < 4; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == acc_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        acc_d[i]    = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '1;
      for (int unsigned i = 0; i < 4; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      for (int unsigned i = 0; i < 4; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  assign held = ~acc_q;

  assign sel_valid = |held;

  always_comb begin
    sel_dir = 2'b00;
    if (held[0]) begin
      sel_dir = 2'b00;
    end else if (held[1]) begin
      sel_dir = 2'b01;
    end else if (held[2]) begin
      sel_dir = 2'b10;
    end else if (held[3]) begin
      sel_dir = 2'b11;
    end
  end

  // A direction change always strobes at once and restarts the long delay.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    valid_d = 1'b0;
    dir_d   = dir_q;
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (sel_valid) begin
          valid_d = 1'b1;
          dir_d   = sel_dir;
          state_d = S_DELAY;
        end
      end
      S_DELAY: begin
        if (!sel_valid) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else if (sel_dir != dir_q) begin
          valid_d = 1'b1;
          dir_d   = sel_dir;
          timer_d = '0;
        end else if (timer_q == RD_LAST) begin
          valid_d = 1'b1;
          timer_d = '0;
          state_d = S_REPEAT;
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      S_REPEAT: begin
        if (!sel_valid) begin
          timer_d = '0;
          state_d = S_IDLE;
        end else if (sel_dir != dir_q) begin
          valid_d = 1'b1;
          dir_d   = sel_dir;
          timer_d = '0;
          state_d = S_DELAY;
        end else if (timer_q == RP_LAST) begin
          valid_d = 1'b1;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_ONE;
        end
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      valid_q <= 1'b0;
      dir_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      valid_q <= valid_d;
      dir_q   <= dir_d;
    end
  end

  assign move_valid = valid_q;
  assign move_dir   = dir_q;

endmodule

// File: tb/tb_button_ctrl.sv
// Scoreboard bench for button_ctrl with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3; expected strobes are queued as (edge number, direction).
module tb_button_ctrl;

  logic       clock;
  logic       clk_en;
  logic       reset;
  logic       up_but, down_but, left_but, right_but;
  logic [3:0] held;
  logic       move_valid;
  logic [1:0] move_dir;

  typedef struct {
    int unsigned c;
    logic [1:0]  d;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc;
  int unsigned vectors;
  int unsigned miscompares;

  button_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3),
    .CNT_W          (25)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .up_but    (up_but),
    .down_but  (down_but),
    .left_but  (left_but),
    .right_but (right_but),
    .held      (held),
    .move_valid(move_valid),
    .move_dir  (move_dir)
  );

  initial clock = 1'b0;
  always begin
    #5;
    if (clk_en) clock = ~clock;
  end

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Strobe monitor: every strobe must match the queue head, every queued
  // strobe must appear on its edge.
  always @(negedge clock) begin
    exp_t e;
    if (move_valid !== 1'b0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL strobe_unexpected: edge %0d dir %b, required no strobe", cyc, move_dir);
      end else begin
        e = exp_q.pop_front();
        if (e.c != cyc || move_dir !== e.d) begin
          miscompares++;
          $display("FAIL strobe: got edge %0d dir %b, required edge %0d dir %b",
                   cyc, move_dir, e.c, e.d);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
      vectors++;
      miscompares++;
      e = exp_q.pop_front();
      $display("FAIL strobe_missing: no strobe at edge %0d, required dir %b", e.c, e.d);
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic tick_to(input int unsigned t);
    while (cyc < t) tick(1);
  endtask

  task automatic expect_strobe(input int unsigned c, input logic [1:0] d);
    exp_t e;
    e.c = c;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    #3 reset = 1'b0;
    #1;
    vectors++;
    if (held !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_held: got %b, required 0000", held);
    end
    vectors++;
    if (move_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b, required 0", move_valid);
    end
    vectors++;
    if (move_dir !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_dir: got %b, required 00", move_dir);
    end
    clk_en = 1'b1;
    tick(3);
    reset = 1'b1;
    tick(2);
    vectors++;
    if (held !== 4'b0000 || move_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: held %b valid %b, required 0000 0", held, move_valid);
    end
  endtask

  task automatic test_glitch;
    logic saw_held;
    saw_held = 1'b0;
    up_but = 1'b0;
    tick(3);
    up_but = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (held !== 4'b0000) saw_held = 1'b1;
    end
    vectors++;
    if (saw_held !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_held: held changed on short pulse, required 0000 throughout");
    end
  endtask

  task automatic test_press_repeat;
    int unsigned e0;
    e0 = cyc;
    up_but = 1'b0;
    expect_strobe(e0 + 7, 2'b00);
    for (int unsigned k = 0; k < 6; k++) expect_strobe(e0 + 17 + 3 * k, 2'b00);
    tick_to(e0 + 5);
    vectors++;
    if (held !== 4'b0000) begin
      miscompares++;
      $display("FAIL press_held_early: got %b at edge +5, required 0000", held);
    end
    tick_to(e0 + 6);
    vectors++;
    if (held !== 4'b0001) begin
      miscompares++;
      $display("FAIL press_held: got %b at edge +6, required 0001", held);
    end
    // release lands so the repeat due at +35 coincides with held falling
    tick_to(e0 + 28);
    up_but = 1'b1;
    tick_to(e0 + 40);
    vectors++;
    if (held !== 4'b0000 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL press_release: held %b pending %0d, required 0000 0", held, exp_q.size());
    end
  endtask

  task automatic test_dir_change;
    int unsigned e0;
    e0 = cyc;
    left_but = 1'b0;
    expect_strobe(e0 + 7, 2'b10);
    for (int unsigned k = 0; k < 4; k++) expect_strobe(e0 + 17 + 3 * k, 2'b10);
    tick_to(e0 + 21);
    up_but = 1'b0;
    expect_strobe(e0 + 28, 2'b00);
    expect_strobe(e0 + 38, 2'b00);
    expect_strobe(e0 + 41, 2'b00);
    expect_strobe(e0 + 44, 2'b00);
    tick_to(e0 + 27);
    vectors++;
    if (held !== 4'b0101) begin
      miscompares++;
      $display("FAIL dir_held_both: got %b, required 0101", held);
    end
    tick_to(e0 + 39);
    up_but = 1'b1;
    expect_strobe(e0 + 46, 2'b10);
    tick_to(e0 + 47);
    left_but = 1'b1;
    tick_to(e0 + 60);
    vectors++;
    if (held !== 4'b0000 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL dir_release: held %b pending %0d, required 0000 0", held, exp_q.size());
    end
  endtask

  task automatic test_short_hold;
    int unsigned e0;
    e0 = cyc;
    right_but = 1'b0;
    expect_strobe(e0 + 7, 2'b11);
    tick_to(e0 + 8);
    right_but = 1'b1;
    tick_to(e0 + 20);
    vectors++;
    if (held !== 4'b0000) begin
      miscompares++;
      $display("FAIL short_held: got %b, required 0000", held);
    end
    right_but = 1'b0;
    expect_strobe(e0 + 27, 2'b11);
    tick_to(e0 + 28);
    right_but = 1'b1;
    tick_to(e0 + 45);
    vectors++;
    if (move_dir !== 2'b11) begin
      miscompares++;
      $display("FAIL short_dir_hold: got %b, required 11", move_dir);
    end
  endtask

  task automatic test_priority;
    int unsigned e0;
    e0 = cyc;
    up_but   = 1'b0;
    down_but = 1'b0;
    expect_strobe(e0 + 7, 2'b00);
    tick_to(e0 + 6);
    vectors++;
    if (held !== 4'b0011) begin
      miscompares++;
      $display("FAIL prio_held: got %b, required 0011", held);
    end
    tick_to(e0 + 9);
    up_but = 1'b1;
    expect_strobe(e0 + 16, 2'b01);
    tick_to(e0 + 17);
    down_but = 1'b1;
    tick_to(e0 + 30);
  endtask

  task automatic test_reset_midop;
    int unsigned e0;
    int unsigned r;
    e0 = cyc;
    down_but = 1'b0;
    expect_strobe(e0 + 7, 2'b01);
    expect_strobe(e0 + 17, 2'b01);
    expect_strobe(e0 + 20, 2'b01);
    tick_to(e0 + 21);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (move_valid !== 1'b0 || held !== 4'b0000 || move_dir !== 2'b00) begin
      miscompares++;
      $display("FAIL midop_reset: valid %b held %b dir %b, required 0 0000 00",
               move_valid, held, move_dir);
    end
    @(posedge clock);
    #1;
    tick(1);
    reset = 1'b1;
    r = cyc;
    expect_strobe(r + 7, 2'b01);
    tick_to(r + 5);
    vectors++;
    if (held !== 4'b0000) begin
      miscompares++;
      $display("FAIL midop_held_early: got %b, required 0000", held);
    end
    tick_to(r + 8);
    down_but = 1'b1;
    tick_to(r + 22);
    vectors++;
    if (held !== 4'b0000 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL midop_end: held %b pending %0d, required 0000 0", held, exp_q.size());
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    clk_en      = 1'b0;
    reset       = 1'b1;
    up_but      = 1'b1;
    down_but    = 1'b1;
    left_but    = 1'b1;
    right_but   = 1'b1;
    test_reset();
    test_glitch();
    test_press_repeat();
    test_dir_change();
    test_short_hold();
    test_priority();
    test_reset_midop();
    tick(5);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL final_queue: %0d strobes never seen, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
